// File: rtl/rca_nibble_seq_if.sv
// rtl/rca_nibble_seq_if.sv - request/result handshake bundle for rca_nibble_seq
// RCA_NIBBLE_SEQ_SUB_EN adds the sub request bit.
interface rca_nibble_seq_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef RCA_NIBBLE_SEQ_SUB_EN
  logic             sub;

  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/rca_nibble_seq.sv
// rtl/rca_nibble_seq.sv - nibble-serial WIDTH-bit adder on a shared 4-bit ripple stage
// RCA_NIBBLE_SEQ_SUB_EN enables a-b via inverted b and forced carry-in.
module rca_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  rca_nibble_seq_if.slave   bus,
  output logic              busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic [4:0]       nib;
  logic [WIDTH-1:0] sum_shift;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef RCA_NIBBLE_SEQ_SUB_EN
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  // Shared 4-bit stage; the new nibble enters the result from the MSB side.
  always_comb begin
    nib       = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'd0, carry};
    sum_shift = WIDTH'({nib[3:0], sum_r} >> 4);
    last      = (cnt == CW'(NIB - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // sum_q/cout_q only load on the final step so outputs hold across RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          sum_r <= sum_shift;
          carry <= nib[4];
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= sum_shift;
            cout_q <= nib[4];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_rca_nibble_seq.sv
// tb/tb_rca_nibble_seq.sv - directed self-checking bench for rca_nibble_seq (WIDTH=16)
// Exercises RCA_NIBBLE_SEQ_SUB_EN vectors when that macro is defined.
module tb_rca_nibble_seq;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   failures;

  rca_nibble_seq_if #(.WIDTH(16)) bus ();

  rca_nibble_seq #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [15:0] es, input logic ec);
    int lat;
    bus.a        = va;
    bus.b        = vb;
    bus.cin      = vc;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    wait_result(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(bus.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [15:0] bb_a [3];
  logic [15:0] bb_b [3];
  logic [15:0] bb_s [3];
  logic        bb_c [3];
  int          acc_cyc [3];
  int          n_acc;
  int          n_res;
  int          cyc;
  int          lat;
  int          seen;
  logic        acc_now;
  logic        hand_now;

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef RCA_NIBBLE_SEQ_SUB_EN
    bus.sub       = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);

    run_op("basic", 16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Backpressure: result held while a second request knocks.
    bus.a        = 16'h00FF;
    bus.b        = 16'h0001;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("bp_busy_run", 32'(busy), 32'd1);
    check("bp_in_ready_run", 32'(bus.in_ready), 32'd0);
    wait_result("bp", lat);
    check("bp_latency", 32'(lat), 32'd4);
    bus.a = 16'h5555;
    bus.b = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_sum", 32'(bus.sum), 32'h0100);
      check("bp_cout", 32'(bus.cout), 32'd0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check("bp_sum_final", 32'(bus.sum), 32'h0100);
    tick();
    bus.out_ready = 1'b0;
    check("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("bp2_busy", 32'(busy), 32'd1);
    wait_result("bp2", lat);
    check("bp2_latency", 32'(lat), 32'd4);
    check("bp2_sum", 32'(bus.sum), 32'h6666);
    check("bp2_cout", 32'(bus.cout), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset on the second RUN edge discards the operation.
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    bb_a[0] = 16'h1234; bb_b[0] = 16'h0FCC; bb_s[0] = 16'h2200; bb_c[0] = 1'b0;
    bb_a[1] = 16'h8000; bb_b[1] = 16'h8000; bb_s[1] = 16'h0000; bb_c[1] = 1'b1;
    bb_a[2] = 16'hABCD; bb_b[2] = 16'h1111; bb_s[2] = 16'hBCDE; bb_c[2] = 1'b0;
    n_acc = 0;
    n_res = 0;
    cyc   = 0;
    bus.out_ready = 1'b1;
    bus.cin       = 1'b0;
    bus.a         = bb_a[0];
    bus.b         = bb_b[0];
    bus.in_valid  = 1'b1;
    while (n_res < 3 && cyc < 60) begin
      acc_now  = bus.in_valid & bus.in_ready;
      hand_now = bus.out_valid;
      if (hand_now) begin
        check("b2b_sum", 32'(bus.sum), 32'(bb_s[n_res]));
        check("b2b_cout", 32'(bus.cout), 32'(bb_c[n_res]));
        n_res++;
      end
      tick();
      cyc++;
      if (acc_now && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) begin
          bus.a = bb_a[n_acc];
          bus.b = bb_b[n_acc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("b2b_results", 32'(n_res), 32'd3);
    check("b2b_accepts", 32'(n_acc), 32'd3);
    if (n_acc == 3) begin
      check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    end
    tick();

`ifdef RCA_NIBBLE_SEQ_SUB_EN
    bus.sub = 1'b1;
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    bus.sub = 1'b0;
    run_op("sub_off", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_nibble_seq.md
Name: rca_nibble_seq

Overview:
- Nibble-serial sequencer that adds two WIDTH-bit operands with a single shared 4-bit ripple-carry add stage, one nibble per clock.
- The carry is registered between nibbles.
- Sits between a requester (valid/ready on input) and a consumer (valid/ready on output).
- Lets wide additions reuse the team's 4-bit adder datapath instead of a WIDTH-bit ripple chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NIB, WIDTH/4 (derived localparam, not overridable), number of nibble steps per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for the LSB nibble.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: synchronous, rst sampled high at a rising edge. Next state IDLE; in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Operand, carry and count registers cleared.
- Reset mid-operation: an in-flight operation is discarded with no output. Reset wins over every other event in the same cycle.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: capture a, b into shift registers; capture cin into carry register; clear nibble counter; go to RUN.
  - in_valid low: stay in IDLE, registers hold.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge: {c,s} = a_sh[3:0] + b_sh[3:0] + carry (5-bit result).
  - s is shifted into sum register from the MSB side (sum_r <= {s, sum_r[WIDTH-1:4]}).
  - carry <= c; a_sh and b_sh shift right by 4; counter increments.
  - After the NIB-th RUN edge (counter == NIB-1 at that edge): go to DONE.
  - Nibble k (bits 4k+3:4k) of the result is therefore produced on the (k+1)-th RUN edge.
- DONE:
  - out_valid=1; sum = sum_r; cout = final carry.
  - sum and cout are held stable while out_ready=0.
  - On out_valid & out_ready at an edge: go to IDLE, out_valid drops next cycle.
  - in_ready=0 in DONE: no accept in the same cycle as result handoff.
- Latency: accept edge E0; out_valid high after edge E0+NIB, i.e. NIB cycles after acceptance.
- Minimum issue interval: NIB+2 cycles (accept, NIB steps, handoff).
- sum/cout outputs after handoff: hold last value until the next DONE. Verification checks them only while out_valid=1.
- Arithmetic: unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
  - Wrap-around: 0xFFFF+0x0001 gives sum=0, cout=1.
- WIDTH=4 (NIB=1): one RUN cycle; the counter must still work at 1 bit.
- busy = (state != IDLE).

Optional Feature:
- Macro: RCA_NIBBLE_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands on the accept edge.
  - When sub=1, b is captured bit-inverted and the carry register is loaded with 1 regardless of cin. Result is a-b modulo 2^WIDTH.
  - cout=1 means no borrow (a>=b); cout=0 means borrow.
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Test Plan:
- WIDTH=16. a=0x1234, b=0x0FCC, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x2200, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry ripples through all nibbles).
- Backpressure: result a=0x00FF+b=0x0001 -> sum=0x0100.
  - Hold out_ready=0 for 5 cycles while pulsing in_valid with other operands.
  - Required: sum, cout and out_valid stable; in_ready=0; the second operation is not accepted until after handoff and the IDLE cycle.
- Reset mid-RUN: accept 0x1111+0x2222, assert rst on the 2nd RUN edge.
  - Next cycle: in_ready=1, out_valid=0, busy=0, sum=0.
  - No result ever emitted for that operation.
  - A following 0x0001+0x0001 returns 0x0002.
- Back-to-back: in_valid held high with out_ready=1 continuously -> accepts spaced exactly 6 cycles apart (NIB+2); each result correct.
- With RCA_NIBBLE_SEQ_SUB_EN:
  - sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0.
  - sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
